multi_edge_detector: RTL and testbench

Parametrised multi-channel edge detector; successor to the single-bit edge detector. Each of WIDTH asynchronous inputs is synchronised, glitch-filtered by a stability counter, and edge-detected into registered one-cycle rising/falling pulses. Per-channel mode bits qualify edges into sticky pending flags with write-1-to-clear, and the flags are OR-reduced into one interrupt. Sits between raw pins/status lines and the interrupt/status logic.

---
 rtl/multi_edge_detector.sv | 61 ++++++
 tb/tb_multi_edge_detector.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel sync, stability filter and edge pulses with
// mode-qualified sticky pending flags OR-reduced into one interrupt.
module multi_edge_detector #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [2*WIDTH-1:0]   mode_i,
  input  logic [WIDTH-1:0]     clr_i,
  output logic [WIDTH-1:0]     rising_o,
  output logic [WIDTH-1:0]     falling_o,
  output logic [WIDTH-1:0]     pending_o,
  output logic                 irq_o
);
  localparam int CW = $clog2(FILT_CYCLES + 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q, level_d, prev_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rise_q, rise_d, fall_q, fall_d, pend_q, pend_d;
    logic                   s, hit;
    assign s   = sync_q[SYNC_STAGES-1];
    assign hit = (s != level_q) && (cnt_q == CW'(FILT_CYCLES - 1));
    // prev_q lags level_q by one edge so a level change becomes a registered pulse
    always_comb begin
      level_d = hit ? s : level_q;
      cnt_d   = (s == level_q || hit) ? '0 : cnt_q + CW'(1);
      rise_d  = level_q & ~prev_q;
      fall_d  = ~level_q & prev_q;
      pend_d  = (rise_d & mode_i[2*i]) | (fall_d & mode_i[2*i+1]) | (pend_q & ~clr_i[i]);
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q  <= '0;
        level_q <= 1'b0;
        prev_q  <= 1'b0;
        cnt_q   <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], a_i[i]};
        level_q <= level_d;
        prev_q  <= level_q;
        cnt_q   <= cnt_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        pend_q  <= pend_d;
      end
    end
    assign rising_o[i]  = rise_q;
    assign falling_o[i] = fall_q;
    assign pending_o[i] = pend_q;
  end

  assign irq_o = |pending_o;
endmodule

// File: tb/tb_multi_edge_detector.sv
// tb_multi_edge_detector: directed checks plus a randomized toggle/glitch run
// whose accepted transitions are counted by the bench and compared to pulses.
module tb_multi_edge_detector;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] a, clr, rising, falling, pending;
  logic [2*W-1:0] mode;
  logic irq;
  int passed = 0, total = 0;
  int n_rise [W];
  int n_fall [W];
  int exp_rise [W];
  int exp_fall [W];
  int glen [W];
  int last [W];
  int ovl = 0;
  bit cnt_en = 1'b0;

  multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(2), .FILT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .a_i(a), .mode_i(mode), .clr_i(clr),
    .rising_o(rising), .falling_o(falling), .pending_o(pending), .irq_o(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_en) begin
      for (int k = 0; k < W; k++) begin
        n_rise[k] += int'(rising[k]);
        n_fall[k] += int'(falling[k]);
      end
      if ((rising & falling) != '0) ovl++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [W-1:0] acc;
    rst = 1'b1; a = '0; mode = '0; clr = '0;
    step(2);
    chk("reset_outs", {rising, falling, pending}, 24'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    rst = 1'b0;

    // channel 0 rising, mode 01
    mode[1:0] = 2'b01;
    a[0] = 1'b1;
    step(6);
    chk("ch0_rise_early", 32'(rising), 32'h0);
    step();
    chk("ch0_rise", 32'(rising), 32'h1);
    chk("ch0_fall_none", 32'(falling), 32'h0);
    chk("ch0_pend", 32'(pending), 32'h1);
    chk("ch0_irq", 32'(irq), 32'h1);
    step();
    chk("ch0_rise_one_cycle", 32'(rising), 32'h0);
    chk("ch0_pend_sticky", 32'(pending), 32'h1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("ch0_clr", 32'(pending), 32'h0);
    chk("ch0_irq_drop", 32'(irq), 32'h0);

    // channel 3 glitch of 3 cycles: filtered out
    a[3] = 1'b1;
    step(3);
    a[3] = 1'b0;
    acc = '0;
    for (int k = 0; k < 12; k++) begin
      step();
      acc |= rising | falling;
    end
    chk("ch3_glitch3", 32'(acc), 32'h0);

    // channel 3 pulse of 4 cycles: accepted, edges 4 apart
    a[3] = 1'b1;
    step(4);
    a[3] = 1'b0;
    step(2);
    chk("ch3_rise_early", 32'(rising), 32'h0);
    step();
    chk("ch3_rise", 32'(rising), 32'h8);
    step(3);
    chk("ch3_fall_early", 32'(falling), 32'h0);
    step();
    chk("ch3_fall", 32'(falling), 32'h8);
    chk("ch3_no_pend", 32'(pending), 32'h0);
    step();
    chk("ch3_fall_one_cycle", 32'(falling), 32'h0);

    // channel 1 mode 10: pending only on falling
    mode[3:2] = 2'b10;
    a[1] = 1'b1;
    step(7);
    chk("ch1_rise", 32'(rising), 32'h2);
    chk("ch1_rise_no_pend", 32'(pending), 32'h0);
    step(10);
    a[1] = 1'b0;
    step(7);
    chk("ch1_fall", 32'(falling), 32'h2);
    chk("ch1_fall_pend", 32'(pending), 32'h2);

    // channel 2 mode 11: set beats simultaneous clear
    mode[5:4] = 2'b11;
    a[2] = 1'b1;
    step(6);
    clr[2] = 1'b1;
    step();
    clr[2] = 1'b0;
    chk("ch2_rise", 32'(rising), 32'h4);
    chk("ch2_set_wins", 32'(pending), 32'h6);
    step(3);
    clr = 8'h04;
    step();
    clr = '0;
    chk("ch2_clr", 32'(pending), 32'h2);
    chk("irq_still", 32'(irq), 32'h1);
    clr = 8'h02;
    step();
    clr = '0;
    chk("all_clr", 32'(pending), 32'h0);
    chk("irq_low", 32'(irq), 32'h0);

    // reset mid-filter on channel 5 with a pending flag on channel 0
    mode[1:0] = 2'b11;
    a[0] = 1'b0;
    step(7);
    chk("ch0_fall_pend", 32'(pending), 32'h1);
    mode[11:10] = 2'b01;
    a[5] = 1'b1;
    step(4);
    rst = 1'b1;
    #1;
    chk("rst_async_outs", {rising, falling, pending}, 24'h0);
    chk("rst_async_irq", 32'(irq), 32'h0);
    step();
    rst = 1'b0;
    step(6);
    chk("post_rst_early", 32'(rising), 32'h0);
    step();
    chk("post_rst_rise", 32'(rising), 32'h24);
    chk("post_rst_pend", 32'(pending), 32'h24);
    step();
    chk("post_rst_single", 32'(rising), 32'h0);

    // randomized run: mode off, every non-glitch toggle spaced >= 10 cycles
    mode = '0;
    clr = '1;
    step(20);
    clr = '0;
    for (int k = 0; k < W; k++) begin
      n_rise[k] = 0; n_fall[k] = 0; exp_rise[k] = 0; exp_fall[k] = 0;
      glen[k] = 0; last[k] = 0;
    end
    cnt_en = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < W; k++) begin
        if (glen[k] > 0) begin
          glen[k]--;
          if (glen[k] == 0) begin
            a[k] = ~a[k];
            last[k] = c;
          end
        end else if (c - last[k] >= 10 && $urandom_range(0, 15) == 0) begin
          a[k] = ~a[k];
          if ($urandom_range(0, 2) == 0) glen[k] = int'($urandom_range(1, 3));
          else begin
            last[k] = c;
            if (a[k]) exp_rise[k]++;
            else exp_fall[k]++;
          end
        end
      end
      step();
    end
    for (int k = 0; k < W; k++) if (glen[k] > 0) begin
      glen[k] = 0;
      a[k] = ~a[k];
    end
    step(15);
    cnt_en = 1'b0;
    for (int k = 0; k < W; k++) begin
      chk($sformatf("rand_rise_ch%0d", k), 32'(n_rise[k]), 32'(exp_rise[k]));
      chk($sformatf("rand_fall_ch%0d", k), 32'(n_fall[k]), 32'(exp_fall[k]));
    end
    chk("rand_no_overlap", 32'(ovl), 32'h0);
    chk("rand_no_pend", 32'(pending), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
